// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-memory request at a time,
// stalls upstream while waiting for ack, and aborts with bus_err_o on timeout.
module mem_access_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUres_i,
    input  logic [31:0] wrdata_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [4:0]  WriteBackPath_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUres_o,
    output logic [31:0] rddata_o,
    output logic [4:0]  WriteBackPath_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    function automatic logic isMisaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_t             state_r, nextState_s;
    logic [CNT_W-1:0]   cnt_r, nextCnt_s;
    logic               memReq_r, memReq_s, memWe_r, memWe_s;
    logic [31:0]        memAddr_r, memAddr_s, memWdata_r, memWdata_s;
    logic               regWrite_r, regWrite_s, memtoReg_r, memtoReg_s;
    logic [31:0]        aluRes_r, aluRes_s, rdData_r, rdData_s;
    logic [4:0]         wbPath_r, wbPath_s;
    logic               misalign_r, misalign_s, busErr_r, busErr_s;
    logic               stall_s, acc_s;

    assign acc_s = MemRead_i | MemWrite_i;

    // Next-state, memory-side and MEM/WB load decisions
    always_comb begin
        nextState_s = state_r;
        nextCnt_s   = cnt_r;
        memReq_s    = memReq_r;
        memWe_s     = memWe_r;
        memAddr_s   = memAddr_r;
        memWdata_s  = memWdata_r;
        regWrite_s  = regWrite_r;
        memtoReg_s  = memtoReg_r;
        aluRes_s    = aluRes_r;
        rdData_s    = rdData_r;
        wbPath_s    = wbPath_r;
        misalign_s  = 1'b0;
        busErr_s    = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!acc_s) begin
                    regWrite_s = RegWrite_i;
                    memtoReg_s = MemtoReg_i;
                    aluRes_s   = ALUres_i;
                    rdData_s   = 32'h0000_0000;
                    wbPath_s   = WriteBackPath_i;
                end else begin
                    regWrite_s = 1'b0;
                    memtoReg_s = 1'b0;
                    aluRes_s   = 32'h0000_0000;
                    rdData_s   = 32'h0000_0000;
                    wbPath_s   = 5'd0;
                    if (isMisaligned(ALUres_i)) begin
                        misalign_s = 1'b1;
                    end else begin
                        stall_s     = 1'b1;
                        nextState_s = WAIT;
                        nextCnt_s   = '0;
                        memReq_s    = 1'b1;
                        memWe_s     = MemWrite_i;
                        memAddr_s   = ALUres_i;
                        memWdata_s  = wrdata_i;
                    end
                end
            end
            WAIT: begin
                // Ack wins over a timeout landing in the same cycle
                if (mem_ack_i) begin
                    nextState_s = IDLE;
                    memReq_s    = 1'b0;
                    memWe_s     = 1'b0;
                    regWrite_s  = RegWrite_i;
                    memtoReg_s  = MemtoReg_i;
                    aluRes_s    = ALUres_i;
                    rdData_s    = memWe_r ? 32'h0000_0000 : mem_rdata_i;
                    wbPath_s    = WriteBackPath_i;
                end else if (cnt_r == CNT_LAST) begin
                    nextState_s = IDLE;
                    memReq_s    = 1'b0;
                    memWe_s     = 1'b0;
                    busErr_s    = 1'b1;
                    regWrite_s  = 1'b0;
                    memtoReg_s  = 1'b0;
                    aluRes_s    = 32'h0000_0000;
                    rdData_s    = 32'h0000_0000;
                    wbPath_s    = 5'd0;
                end else begin
                    stall_s   = 1'b1;
                    nextCnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                nextState_s = IDLE;
                memReq_s    = 1'b0;
                memWe_s     = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= 32'h0000_0000;
            memWdata_r <= 32'h0000_0000;
            regWrite_r <= 1'b0;
            memtoReg_r <= 1'b0;
            aluRes_r   <= 32'h0000_0000;
            rdData_r   <= 32'h0000_0000;
            wbPath_r   <= 5'd0;
            misalign_r <= 1'b0;
            busErr_r   <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            cnt_r      <= nextCnt_s;
            memReq_r   <= memReq_s;
            memWe_r    <= memWe_s;
            memAddr_r  <= memAddr_s;
            memWdata_r <= memWdata_s;
            regWrite_r <= regWrite_s;
            memtoReg_r <= memtoReg_s;
            aluRes_r   <= aluRes_s;
            rdData_r   <= rdData_s;
            wbPath_r   <= wbPath_s;
            misalign_r <= misalign_s;
            busErr_r   <= busErr_s;
        end
    end

    // Reset forces the hold request low even if a new access is presented
    assign stall_o         = stall_s & rst_i;
    assign mem_req_o       = memReq_r;
    assign mem_we_o        = memWe_r;
    assign mem_addr_o      = memAddr_r;
    assign mem_wdata_o     = memWdata_r;
    assign RegWrite_o      = regWrite_r;
    assign MemtoReg_o      = memtoReg_r;
    assign ALUres_o        = aluRes_r;
    assign rddata_o        = rdData_r;
    assign WriteBackPath_o = wbPath_r;
    assign misalign_o      = misalign_r;
    assign bus_err_o       = busErr_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYC = 4).
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ALUres_i, wrdata_i;
    logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
    logic [4:0]  WriteBackPath_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALUres_o, rddata_o;
    logic [4:0]  WriteBackPath_o;
    logic        misalign_o, bus_err_o;

    int testCnt = 0;
    int failCnt = 0;
    int stallCnt;

    mem_access_stage #(.TIMEOUT_CYC(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUres_i(ALUres_i), .wrdata_i(wrdata_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .WriteBackPath_i(WriteBackPath_i), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUres_o(ALUres_o), .rddata_o(rddata_o),
        .WriteBackPath_o(WriteBackPath_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setOp(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wbp);
        MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw; MemtoReg_i = m2r;
        ALUres_i = addr; wrdata_i = wd; WriteBackPath_i = wbp;
    endtask

    // Drives one aligned access; ack given on WAIT cycle ackAt (-1 = never).
    task automatic runAccess(input int ackAt, input logic [31:0] rdata, input logic expWe,
                             input logic [31:0] expAddr, input logic [31:0] expWd,
                             output int stalls);
        logic st;
        bit done;
        stalls = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            mem_ack_i   = (cyc >= 1) && (cyc - 1 == ackAt);
            mem_rdata_i = mem_ack_i ? rdata : 32'hA5A5_A5A5;
            #1;
            st = stall_o;
            if (st) stalls++;
            step();
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'h0000_0000;
            if (cyc >= 1 && !st) begin
                done = 1'b1;
            end else begin
                checkVal("wait_req", {31'd0, mem_req_o}, 32'd1);
                checkVal("wait_we", {31'd0, mem_we_o}, {31'd0, expWe});
                checkVal("wait_addr", mem_addr_o, expAddr);
                checkVal("wait_wdata", mem_wdata_o, expWd);
            end
        end
        if (!done) checkVal("access_bound", 32'd0, 32'd1);
    endtask

    initial begin
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        setOp(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd1);
        rst_i = 1'b0;
        #2;
        checkVal("rst_stall", {31'd0, stall_o}, 32'd0);
        checkVal("rst_req", {31'd0, mem_req_o}, 32'd0);
        checkVal("rst_regwrite", {31'd0, RegWrite_o}, 32'd0);
        checkVal("rst_alures", ALUres_o, 32'd0);
        setOp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rst_i = 1'b1;
        step();

        // Non-memory op passes through in one cycle
        setOp(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5);
        #1 checkVal("alu_stall", {31'd0, stall_o}, 32'd0);
        step();
        checkVal("alu_regwrite", {31'd0, RegWrite_o}, 32'd1);
        checkVal("alu_alures", ALUres_o, 32'h10);
        checkVal("alu_wbpath", {27'd0, WriteBackPath_o}, 32'd5);
        checkVal("alu_rddata", rddata_o, 32'd0);

        // Load, ack on 4th WAIT cycle (coincides with timeout: ack wins)
        setOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7);
        runAccess(3, 32'hDEAD_BEEF, 1'b0, 32'h100, 32'h0, stallCnt);
        checkVal("ld_stall_cycles", stallCnt, 32'd4);
        checkVal("ld_rddata", rddata_o, 32'hDEAD_BEEF);
        checkVal("ld_memtoreg", {31'd0, MemtoReg_o}, 32'd1);
        checkVal("ld_regwrite", {31'd0, RegWrite_o}, 32'd1);
        checkVal("ld_wbpath", {27'd0, WriteBackPath_o}, 32'd7);
        checkVal("ld_req_drop", {31'd0, mem_req_o}, 32'd0);
        checkVal("ld_no_buserr", {31'd0, bus_err_o}, 32'd0);

        // Store, ack on first WAIT cycle
        setOp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h1234_5678, 5'd0);
        runAccess(0, 32'hFFFF_0000, 1'b1, 32'h40, 32'h1234_5678, stallCnt);
        checkVal("st_stall_cycles", stallCnt, 32'd1);
        checkVal("st_regwrite", {31'd0, RegWrite_o}, 32'd0);
        checkVal("st_rddata", rddata_o, 32'd0);
        checkVal("st_req_drop", {31'd0, mem_req_o}, 32'd0);

        // Read+write together is a write
        setOp(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_0001, 5'd9);
        runAccess(1, 32'h5555_AAAA, 1'b1, 32'h80, 32'hCAFE_0001, stallCnt);
        checkVal("rw_rddata", rddata_o, 32'd0);

        // Misaligned load
        setOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd3);
        #1 checkVal("mis_stall", {31'd0, stall_o}, 32'd0);
        step();
        checkVal("mis_pulse", {31'd0, misalign_o}, 32'd1);
        checkVal("mis_req", {31'd0, mem_req_o}, 32'd0);
        checkVal("mis_regwrite", {31'd0, RegWrite_o}, 32'd0);
        checkVal("mis_wbpath", {27'd0, WriteBackPath_o}, 32'd0);
        setOp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        checkVal("mis_once", {31'd0, misalign_o}, 32'd0);

        // Timeout: no ack
        setOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd4);
        runAccess(-1, 32'h0, 1'b0, 32'h200, 32'h0, stallCnt);
        checkVal("to_stall_cycles", stallCnt, 32'd4);
        checkVal("to_buserr", {31'd0, bus_err_o}, 32'd1);
        checkVal("to_req", {31'd0, mem_req_o}, 32'd0);
        checkVal("to_regwrite", {31'd0, RegWrite_o}, 32'd0);
        setOp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        #1 checkVal("late_ack_stall", {31'd0, stall_o}, 32'd0);
        step();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        checkVal("to_once", {31'd0, bus_err_o}, 32'd0);
        checkVal("late_ack_rddata", rddata_o, 32'd0);
        checkVal("late_ack_req", {31'd0, mem_req_o}, 32'd0);

        // Reset in the middle of WAIT
        setOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd6);
        step();
        checkVal("rw_wait_req", {31'd0, mem_req_o}, 32'd1);
        #1 rst_i = 1'b0;
        #1;
        checkVal("rstw_req", {31'd0, mem_req_o}, 32'd0);
        checkVal("rstw_stall", {31'd0, stall_o}, 32'd0);
        checkVal("rstw_addr", mem_addr_o, 32'd0);
        step();
        setOp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #2 rst_i = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        checkVal("rstw_late_ack", rddata_o, 32'd0);
        checkVal("rstw_idle_req", {31'd0, mem_req_o}, 32'd0);
        setOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0304, 32'h0, 5'd8);
        runAccess(1, 32'h0BAD_F00D, 1'b0, 32'h304, 32'h0, stallCnt);
        checkVal("post_rst_stall", stallCnt, 32'd2);
        checkVal("post_rst_rddata", rddata_o, 32'h0BAD_F00D);
        checkVal("post_rst_wbpath", {27'd0, WriteBackPath_o}, 32'd8);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
